// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter that shares one register bank between several requesters.
// Each granted write runs IDLE -> WRITE -> ACK; every output is registered.
module reg_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int NUM_REG = 3,
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REG-1:0]        reg_en,
  output logic [DATA_W-1:0]         reg_data,
  output logic                      busy,
  output logic                      addr_err
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, ACK = 2'd2} state_t;

  state_t              state_r, state_s;
  logic [PTR_W-1:0]    rr_ptr_r, rr_ptr_s;
  logic [PTR_W-1:0]    win_r, win_s;
  logic [PTR_W-1:0]    pick_s;
  logic                pick_valid_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic [ADDR_W-1:0]   pick_addr_s;
  logic [DATA_W-1:0]   pick_data_s;
  logic [NUM_REQ-1:0]  gnt_s, ack_s;
  logic [NUM_REG-1:0]  reg_en_s;
  logic [DATA_W-1:0]   reg_data_s;
  logic                busy_s, addr_err_s;

  function automatic logic [NUM_REQ-1:0] req_onehot(input logic [PTR_W-1:0] idx);
    for (int j = 0; j < NUM_REQ; j++) begin
      req_onehot[j] = (idx == PTR_W'(j));
    end
  endfunction

  function automatic logic [NUM_REG-1:0] reg_onehot(input logic [ADDR_W-1:0] a);
    for (int j = 0; j < NUM_REG; j++) begin
      reg_onehot[j] = (a == ADDR_W'(j));
    end
  endfunction

  function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W+1)'(NUM_REG));
  endfunction

  // Round-robin search: scanning downward lets the nearest set bit after rr_ptr win.
  always_comb begin : rr_search
    int idx;
    idx          = 0;
    pick_s       = rr_ptr_r;
    pick_valid_s = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx          = (int'(rr_ptr_r) + k) % NUM_REQ;
      pick_s       = req[idx] ? PTR_W'(idx) : pick_s;
      pick_valid_s = pick_valid_s | req[idx];
    end
  end

  assign pick_addr_s = req_addr[pick_s*ADDR_W +: ADDR_W];
  assign pick_data_s = req_data[pick_s*DATA_W +: DATA_W];

  // State register plus every registered output; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= IDLE;
      rr_ptr_r <= {PTR_W{1'b0}};
      win_r    <= {PTR_W{1'b0}};
      addr_r   <= {ADDR_W{1'b0}};
      gnt      <= {NUM_REQ{1'b0}};
      ack      <= {NUM_REQ{1'b0}};
      reg_en   <= {NUM_REG{1'b0}};
      reg_data <= {DATA_W{1'b0}};
      busy     <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      state_r  <= state_s;
      rr_ptr_r <= rr_ptr_s;
      win_r    <= win_s;
      addr_r   <= addr_s;
      gnt      <= gnt_s;
      ack      <= ack_s;
      reg_en   <= reg_en_s;
      reg_data <= reg_data_s;
      busy     <= busy_s;
      addr_err <= addr_err_s;
    end
  end

  // Next-state logic: fixed three-cycle transaction.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = pick_valid_s ? WRITE : IDLE;
      WRITE:   state_s = ACK;
      ACK:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs and transaction context.
  always_comb begin
    gnt_s      = gnt;
    ack_s      = ack;
    reg_en_s   = reg_en;
    reg_data_s = reg_data;
    busy_s     = busy;
    addr_err_s = addr_err;
    rr_ptr_s   = rr_ptr_r;
    win_s      = win_r;
    addr_s     = addr_r;
    case (state_r)
      IDLE: begin
        ack_s      = {NUM_REQ{1'b0}};
        addr_err_s = 1'b0;
        if (pick_valid_s) begin
          win_s      = pick_s;
          addr_s     = pick_addr_s;
          gnt_s      = req_onehot(pick_s);
          busy_s     = 1'b1;
          reg_en_s   = addr_valid(pick_addr_s) ? reg_onehot(pick_addr_s) : {NUM_REG{1'b0}};
          reg_data_s = pick_data_s;
        end else begin
          gnt_s    = {NUM_REQ{1'b0}};
          busy_s   = 1'b0;
          reg_en_s = {NUM_REG{1'b0}};
        end
      end
      WRITE: begin
        reg_en_s   = {NUM_REG{1'b0}};
        ack_s      = req_onehot(win_r);
        addr_err_s = ~addr_valid(addr_r);
        rr_ptr_s   = (win_r == LAST_REQ) ? {PTR_W{1'b0}} : win_r + PTR_W'(1);
      end
      ACK: begin
        gnt_s      = {NUM_REQ{1'b0}};
        ack_s      = {NUM_REQ{1'b0}};
        reg_en_s   = {NUM_REG{1'b0}};
        busy_s     = 1'b0;
        addr_err_s = 1'b0;
      end
      default: begin
        gnt_s      = {NUM_REQ{1'b0}};
        ack_s      = {NUM_REQ{1'b0}};
        reg_en_s   = {NUM_REG{1'b0}};
        busy_s     = 1'b0;
        addr_err_s = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares the 8-bit register bank (one 8-bit register per destination, each with its own enable) between several write requesters: ALU writeback, bus load, immediate load, and so on.
- Arbitrates round-robin and drives exactly one register enable for one cycle per granted write.
- Acknowledges the winning requester.
- Sits between the control unit's requesters and the register bank.

Parameters:
- NUM_REQ, 4, number of write requesters.
- NUM_REG, 3, number of registers in the bank; valid addresses are 0..NUM_REG-1.
- ADDR_W, 2, width of each requester's destination address.
- DATA_W, 8, register data width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- req  input  NUM_REQ  per-requester write request; level, held until ack.
- req_addr  input  NUM_REQ*ADDR_W  packed destination addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_data  input  NUM_REQ*DATA_W  packed write data; requester i at [i*DATA_W +: DATA_W].
- gnt  output  NUM_REQ  one-hot grant, high through WRITE and ACK of the owning transaction.
- ack  output  NUM_REQ  one-hot, one-cycle completion pulse to the winner.
- reg_en  output  NUM_REG  one-hot register enable, one cycle per write.
- reg_data  output  DATA_W  data to the register bank data_in.
- busy  output  1  high while state is not IDLE.
- addr_err  output  1  one-cycle pulse, coincident with ack, when the latched address is >= NUM_REG.

Behaviour:
- All outputs are registered.
- Reset (reset==0 at a rising edge):
  - state=IDLE, rr_ptr=0.
  - gnt, ack, reg_en, reg_data, busy and addr_err all 0.
  - Reset takes priority over every other event, including mid-transaction; an aborted write never pulses ack.
  - The register bank's own reset is independent.
- FSM states: IDLE -> WRITE -> ACK -> IDLE. Every transaction takes exactly 3 cycles; maximum throughput is one write per 3 cycles.
- IDLE, some req bit set at a rising edge:
  - Winner w is the first set bit searching upward from rr_ptr, wrapping NUM_REQ-1 -> 0.
  - Latch req_addr[w] and req_data[w].
  - Set gnt=onehot(w) and busy=1.
  - Set reg_en=onehot(addr) if addr<NUM_REG, else 0.
  - Set reg_data=data.
  - Go to WRITE.
- IDLE, no req: stay in IDLE with all outputs 0.
- WRITE (one cycle): reg_en and reg_data are presented; the bank captures at the closing edge. At that edge:
  - reg_en<=0.
  - ack<=onehot(w).
  - addr_err<=(addr>=NUM_REG).
  - rr_ptr<=(w+1) mod NUM_REQ.
  - Go to ACK.
- ACK (one cycle): at the closing edge, ack, gnt, busy and addr_err return to 0; go to IDLE.
- The winner's req is ignored from the grant until IDLE. Dropping req mid-transaction does not cancel the write; latched address and data are used. A requester still holding req at IDLE re-competes normally.
- reg_data holds its last value outside WRITE; reg_data is defined only when reg_en is non-zero.
- Request arrivals during WRITE/ACK are not lost; they are evaluated at the next IDLE edge.
- Fairness: with all NUM_REQ requesting continuously, each requester is granted once per NUM_REQ transactions.
- Invariants:
  - At most one bit set in gnt, ack and reg_en.
  - reg_en is never high outside WRITE.
  - ack is never high outside ACK.

Test Plan:
- Reset, then req=4'b0010, addr1=2, data1=8'hA5.
  - Expected: edge 1 gnt=0010, reg_en=100, reg_data=A5.
  - Edge 2: reg_en=0, ack=0010.
  - Edge 3: ack=0, busy=0.
  - Bank reg2 reads A5.
- req=4'b1111 held, addr_i=i mod 3, data_i=8'h10+i.
  - Expected grant order 0,1,2,3,0, one grant every 3 cycles.
  - Each reg_en pulse carries the matching data.
- req=4'b1000 with addr=3 (invalid, NUM_REG=3).
  - Expected: reg_en stays 000 throughout.
  - ack=1000 and addr_err=1 in the same cycle.
  - rr_ptr advances to 0.
- req0 asserted, then dropped during WRITE with data changed to 8'hFF after the grant.
  - Expected: the write completes with the originally latched data; ack0 still pulses.
- Transaction in WRITE, reset driven low for one edge.
  - Expected: next cycle all outputs 0, state IDLE.
  - No ack pulse; the next grant starts from requester 0.
- req2 and req3 raised during ACK of a requester-1 transaction.
  - Expected: at the IDLE edge requester 2 wins (rr_ptr=2), then requester 3.
